// File: rtl/corr_ram_ring.sv
// corr_ram_ring
// Multi-channel circular sample buffer feeding the correlator MAC array.
// Each channel owns a DEPTH-word ring in a shared dual-port RAM addressed
// by {chan, ptr}. Writes append to a channel ring. A readout request streams
// the most recent rd_len words of one channel, oldest first, through a
// registered valid/ready output.
//
// Ports
//   clk, rst      clock, synchronous active-high reset (rst wins over ena)
//   ena           clock enable, low freezes all state and outputs
//   wr_valid/wr_chan/wr_data   append one word to a channel ring
//   wr_drop       one-cycle pulse, write hit the channel being read
//   rd_start/rd_chan/rd_len    readout request (1..DEPTH words)
//   rd_err        one-cycle pulse, request length was 0 or exceeded fill
//   busy          readout in progress
//   dout/dout_valid/dout_ready/dout_last   registered output stream
//   fill          per-channel word count, channel c at [c*LW +: LW]
//
// state  | meaning
// IDLE   | no readout, rd_start is evaluated
// STREAM | readout active, words loaded into dout as the consumer allows

module corr_ram_ring #(
  parameter int NUM_PARALLEL = 8,
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_CORRS    = 4,
  parameter int DEPTH        = 16,
  localparam int W  = NUM_PARALLEL * DATA_WIDTH,
  localparam int CW = (NUM_CORRS > 1) ? $clog2(NUM_CORRS) : 1,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    wr_valid,
  input  logic [CW-1:0]           wr_chan,
  input  logic [W-1:0]            wr_data,
  output logic                    wr_drop,
  input  logic                    rd_start,
  input  logic [CW-1:0]           rd_chan,
  input  logic [LW-1:0]           rd_len,
  output logic                    rd_err,
  output logic                    busy,
  output logic [W-1:0]            dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic [NUM_CORRS*LW-1:0] fill
);

  // With a single channel the channel bit is not part of the RAM address.
  localparam int AW = (NUM_CORRS > 1) ? (CW + PW) : PW;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state, state_next;

  logic [W-1:0]    mem [NUM_CORRS*DEPTH];
  logic [PW-1:0]   wp [NUM_CORRS];
  logic [LW-1:0]   fill_r [NUM_CORRS];

  logic [CW-1:0]   act_chan;
  logic [PW-1:0]   rp;
  logic [LW-1:0]   remaining;

  logic            wr_blocked;
  logic            wr_accept;
  logic            rd_req_idle;
  logic            len_ok;
  logic            rd_accept;
  logic            rd_reject;
  logic            load;
  logic            done;

  logic [CW+PW-1:0] waddr_full;
  logic [CW+PW-1:0] raddr_full;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;

  assign busy = (state == STREAM);

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  // busy is the registered state, so a write issued in the same cycle a
  // request is accepted on the same channel still lands; the read window
  // was computed from the pre-write pointer and excludes it.
  assign wr_blocked = wr_valid && busy && (wr_chan == act_chan);
  assign wr_accept  = wr_valid && !wr_blocked;

  assign rd_req_idle = rd_start && (state == IDLE);
  assign len_ok      = (rd_len != '0) && (rd_len <= fill_r[rd_chan]);
  assign rd_accept   = rd_req_idle && len_ok;
  assign rd_reject   = rd_req_idle && !len_ok;

  assign load = (state == STREAM) && (!dout_valid || dout_ready) && (remaining != '0);
  assign done = (state == STREAM) && dout_valid && dout_ready && (remaining == '0);

  assign waddr_full = {wr_chan, wp[wr_chan]};
  assign raddr_full = {act_chan, rp};
  assign waddr      = waddr_full[AW-1:0];
  assign raddr      = raddr_full[AW-1:0];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (ena) begin
      case (state)
        IDLE:    if (rd_accept) state_next = STREAM;
        STREAM:  if (done)      state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Write side: pointers and fill counts
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CORRS; c++) begin
        wp[c]     <= '0;
        fill_r[c] <= '0;
      end
      wr_drop <= 1'b0;
    end else if (ena) begin
      wr_drop <= wr_blocked;
      if (wr_accept) begin
        wp[wr_chan] <= wp[wr_chan] + 1'b1;
        // Once full, the ring overwrites its oldest word and fill stays put.
        if (fill_r[wr_chan] != LW'(DEPTH)) begin
          fill_r[wr_chan] <= fill_r[wr_chan] + 1'b1;
        end
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && ena && wr_accept) begin
      mem[waddr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read side: window setup and registered output stage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      act_chan   <= '0;
      rp         <= '0;
      remaining  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      rd_err     <= 1'b0;
    end else if (ena) begin
      rd_err <= rd_reject;
      if (rd_accept) begin
        act_chan  <= rd_chan;
        // rd_len == DEPTH wraps to rp == wp, the oldest word of a full ring.
        rp        <= wp[rd_chan] - rd_len[PW-1:0];
        remaining <= rd_len;
      end
      if (load) begin
        dout       <= mem[raddr];
        dout_valid <= 1'b1;
        dout_last  <= (remaining == LW'(1));
        rp         <= rp + 1'b1;
        remaining  <= remaining - 1'b1;
      end else if (done) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Fill vector packing
  // ---------------------------------------------------------------------
  always_comb begin
    fill = '0;
    for (int c = 0; c < NUM_CORRS; c++) begin
      fill[c*LW +: LW] = fill_r[c];
    end
  end

endmodule

// File: tb/tb_corr_ram_ring.sv
// Directed testbench for corr_ram_ring with default parameters
// (8 x 12-bit samples, 4 channels, 16-word rings).
module tb_corr_ram_ring;

  localparam int W  = 96;
  localparam int CW = 2;
  localparam int LW = 5;
  localparam int NC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic              wr_valid;
  logic [CW-1:0]     wr_chan;
  logic [W-1:0]      wr_data;
  logic              wr_drop;
  logic              rd_start;
  logic [CW-1:0]     rd_chan;
  logic [LW-1:0]     rd_len;
  logic              rd_err;
  logic              busy;
  logic [W-1:0]      dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic [NC*LW-1:0]  fill;

  int n_cmp = 0;
  int n_err = 0;

  // backpressure scenario, one entry per cycle after the request is accepted
  int bp_rdy [9] = '{1, 0, 0, 1, 0, 1, 1, 1, 1};
  int bp_val [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int bp_dat [9] = '{0, 2, 2, 2, 3, 3, 4, 5, 0};
  int bp_lst [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  int bp_bsy [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

  corr_ram_ring dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .wr_valid   (wr_valid),
    .wr_chan    (wr_chan),
    .wr_data    (wr_data),
    .wr_drop    (wr_drop),
    .rd_start   (rd_start),
    .rd_chan    (rd_chan),
    .rd_len     (rd_len),
    .rd_err     (rd_err),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: called at a negedge, return at the following negedge.
  task automatic do_write(input int ch, input int val);
    wr_valid = 1'b1;
    wr_chan  = CW'(ch);
    wr_data  = W'(val);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input int ch, input int len);
    rd_start = 1'b1;
    rd_chan  = CW'(ch);
    rd_len   = LW'(len);
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (fill !== '0) begin n_err++; $display("FAIL reset_fill: got %0h want 0", fill); end
    n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout: got %0h want 0", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", dout_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    do_read(0, 1);
    n_cmp++; if (rd_err !== 1'b1) begin n_err++; $display("FAIL empty_rd_err: got %0b want 1", rd_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL empty_busy: got %0b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL rd_err_pulse: got %0b want 0", rd_err); end
    do_read(0, 0);
    n_cmp++; if (rd_err !== 1'b1) begin n_err++; $display("FAIL len0_rd_err: got %0b want 1", rd_err); end
  endtask

  task automatic test_basic_stream();
    for (int v = 1; v <= 5; v++) do_write(2, v);
    n_cmp++; if (fill[2*LW +: LW] !== LW'(5)) begin n_err++; $display("FAIL basic_fill2: got %0d want 5", fill[2*LW +: LW]); end
    dout_ready = 1'b1;
    do_read(2, 3);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %0b want 1", busy); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_c1: got %0b want 0", dout_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b1 || dout !== W'(3 + i)) begin
        n_err++; $display("FAIL basic_word%0d: got v=%0b d=%0h want v=1 d=%0h", i, dout_valid, dout, 3 + i);
      end
      n_cmp++; if (dout_last !== (i == 2)) begin n_err++; $display("FAIL basic_last%0d: got %0b want %0b", i, dout_last, i == 2); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_end: got busy=%0b v=%0b want 0 0", busy, dout_valid);
    end
  endtask

  task automatic test_wrap();
    for (int v = 1; v <= 20; v++) do_write(1, v);
    n_cmp++; if (fill[1*LW +: LW] !== LW'(16)) begin n_err++; $display("FAIL wrap_fill1: got %0d want 16", fill[1*LW +: LW]); end
    do_read(1, 16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b1 || dout !== W'(5 + i) || dout_last !== (i == 15)) begin
        n_err++; $display("FAIL wrap_word%0d: got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b", i, dout_valid, dout, dout_last, 5 + i, i == 15);
      end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_busy_end: got %0b want 0", busy); end
    do_read(1, 17);
    n_cmp++; if (rd_err !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL wrap_len17: got err=%0b busy=%0b want 1 0", rd_err, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    // chan 2 holds 1..5, so the last four words are 2..5
    do_read(2, 4);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (dout_valid !== bp_val[i][0] || busy !== bp_bsy[i][0] || dout_last !== bp_lst[i][0]) begin
        n_err++; $display("FAIL bp_ctrl_c%0d: got v=%0b b=%0b l=%0b want v=%0d b=%0d l=%0d",
                          i + 1, dout_valid, busy, dout_last, bp_val[i], bp_bsy[i], bp_lst[i]);
      end
      if (bp_val[i] != 0) begin
        n_cmp++; if (dout !== W'(bp_dat[i])) begin
          n_err++; $display("FAIL bp_data_c%0d: got %0h want %0h", i + 1, dout, bp_dat[i]);
        end
      end
      dout_ready = bp_rdy[i][0];
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_collision();
    do_write(0, 'hA);
    do_write(0, 'hB);
    do_write(0, 'hC);
    do_read(0, 3);
    // c1: readout active, write to the channel being read
    do_write(0, 'hFF);
    n_cmp++; if (wr_drop !== 1'b1) begin n_err++; $display("FAIL coll_drop: got %0b want 1", wr_drop); end
    n_cmp++; if (fill[0*LW +: LW] !== LW'(3)) begin n_err++; $display("FAIL coll_fill0: got %0d want 3", fill[0*LW +: LW]); end
    n_cmp++; if (dout !== W'('hA)) begin n_err++; $display("FAIL coll_word0: got %0h want a", dout); end
    do_write(3, 'h33);
    n_cmp++; if (wr_drop !== 1'b0) begin n_err++; $display("FAIL coll_drop_pulse: got %0b want 0", wr_drop); end
    n_cmp++; if (fill[3*LW +: LW] !== LW'(1)) begin n_err++; $display("FAIL coll_fill3: got %0d want 1", fill[3*LW +: LW]); end
    n_cmp++; if (dout !== W'('hB)) begin n_err++; $display("FAIL coll_word1: got %0h want b", dout); end
    do_read(3, 1);
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL busy_rd_ignored: got %0b want 0", rd_err); end
    n_cmp++; if (dout !== W'('hC) || dout_last !== 1'b1) begin
      n_err++; $display("FAIL coll_word2: got d=%0h l=%0b want d=c l=1", dout, dout_last);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL coll_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    // request in the first cycle after busy falls
    do_read(3, 1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %0b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (dout_valid !== 1'b1 || dout !== W'('h33) || dout_last !== 1'b1) begin
      n_err++; $display("FAIL b2b_word: got v=%0b d=%0h l=%0b want 1 33 1", dout_valid, dout, dout_last);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got busy=%0b v=%0b want 0 0", busy, dout_valid);
    end
  endtask

  task automatic test_midstream();
    // chan 1 holds 5..20 in a full ring; last four are 17..20
    do_read(1, 4);
    @(negedge clk);
    n_cmp++; if (dout !== W'(17) || dout_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_word0: got v=%0b d=%0h want v=1 d=11", dout_valid, dout);
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (dout !== W'(17) || dout_valid !== 1'b1 || busy !== 1'b1 || dout_last !== 1'b0) begin
        n_err++; $display("FAIL mid_freeze%0d: got d=%0h v=%0b b=%0b l=%0b want d=11 v=1 b=1 l=0",
                          i, dout, dout_valid, busy, dout_last);
      end
    end
    ena = 1'b1;
    @(negedge clk);
    n_cmp++; if (dout !== W'(18) || dout_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_resume: got v=%0b d=%0h want v=1 d=12", dout_valid, dout);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (dout_valid !== 1'b0 || busy !== 1'b0 || dout_last !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_ctrl: got v=%0b b=%0b l=%0b want 0 0 0", dout_valid, busy, dout_last);
    end
    n_cmp++; if (fill !== '0 || dout !== '0) begin
      n_err++; $display("FAIL mid_rst_state: got fill=%0h dout=%0h want 0 0", fill, dout);
    end
  endtask

  initial begin
    rst        = 1'b1;
    ena        = 1'b1;
    wr_valid   = 1'b0;
    wr_chan    = '0;
    wr_data    = '0;
    rd_start   = 1'b0;
    rd_chan    = '0;
    rd_len     = '0;
    dout_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_stream();
    test_wrap();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
